// File: rtl/asr8_fifo.sv
// 8-deep FIFO built on a shift register: every push shifts the whole array,
// and reads come from a tap at count-1 (first-word fall-through).
module asr8_fifo #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         wr_valid,
    input  logic [N-1:0] wr_data,
    output logic         wr_ready,
    output logic         rd_valid,
    output logic [N-1:0] rd_data,
    input  logic         rd_ready,
    output logic [3:0]   count,
    output logic         full,
    output logic         empty,
    output logic         ovf
);

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned AW    = 3;

    logic [DEPTH-1:0][N-1:0] sr;
    logic [CW-1:0]           cnt_q;
    logic                    ovf_q;
    logic [AW-1:0]           rd_addr;
    logic                    push;
    logic                    pop;

    // Status flags decode the registered count only, so rd_ready never reaches wr_ready.
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == CW'(0));
    assign wr_ready = ~full;
    assign rd_valid = ~empty;
    assign count    = cnt_q;
    assign ovf      = ovf_q;

    assign push = wr_valid & wr_ready;
    assign pop  = rd_valid & rd_ready;

    // sr[0] holds the newest word, sr[count-1] the oldest.
    assign rd_addr = AW'(cnt_q - CW'(1));
    assign rd_data = empty ? '0 : sr[rd_addr];

    // Shift storage; a pop alone leaves the array untouched and just moves the tap.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sr <= '0;
        end else if (push) begin
            sr <= {sr[DEPTH-2:0], wr_data};
        end
    end

    // Occupancy counter; a simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky overflow: a write offered while full is dropped and flagged.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf_q <= 1'b0;
        end else if (wr_valid && full) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_asr8_fifo.sv
// Directed bench for asr8_fifo: stimulus queues expected read words,
// an independent monitor compares them whenever a read handshake is presented.
module tb_asr8_fifo;

    logic       clk;
    logic       clr_n;
    logic       wr_valid;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       rd_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    asr8_fifo #(.N(4)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (clr_n && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: got %0h expected no read at %0t", rd_data, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    failures++;
                    $display("FAIL rd_data: got %0h expected %0h at %0t", rd_data, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        exp_q.push_back(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_count"},    32'(count),    32'd0);
        check({tag, "_empty"},    32'(empty),    32'd1);
        check({tag, "_full"},     32'(full),     32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check({tag, "_rd_data"},  32'(rd_data),  32'd0);
        check({tag, "_ovf"},      32'(ovf),      32'd0);
    endtask

    initial begin
        clr_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 4'h0;
        rd_ready = 1'b0;
        #3;
        check_idle_reset("reset");
        @(negedge clk);
        clr_n = 1'b1;
        tick();

        // Reads while empty do nothing.
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_pop_count",    32'(count),    32'd0);
            check("empty_pop_ovf",      32'(ovf),      32'd0);
            check("empty_pop_rd_valid", 32'(rd_valid), 32'd0);
        end
        rd_ready = 1'b0;

        // First-word fall-through latency.
        wr_valid = 1'b1;
        wr_data  = 4'hA;
        exp_q.push_back(4'hA);
        check("fwft_same_cycle_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        wr_valid = 1'b0;
        check("fwft_next_rd_valid", 32'(rd_valid), 32'd1);
        check("fwft_next_rd_data",  32'(rd_data),  32'hA);
        drain(1);
        check("fwft_drained_empty", 32'(empty), 32'd1);

        // Basic ordering.
        push(4'd3); push(4'd2); push(4'd4); push(4'd5);
        check("order_count",   32'(count),   32'd4);
        check("order_rd_data", 32'(rd_data), 32'd3);
        drain(4);
        check("order_empty",   32'(empty),   32'd1);
        check("order_rd_data0", 32'(rd_data), 32'd0);

        // Simultaneous push and pop at count 3.
        push(4'd7); push(4'd6); push(4'd5);
        wr_valid = 1'b1;
        wr_data  = 4'd9;
        rd_ready = 1'b1;
        exp_q.push_back(4'd9);
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("pushpop_count",   32'(count),   32'd3);
        check("pushpop_rd_data", 32'(rd_data), 32'd6);
        drain(3);
        check("pushpop_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain.
        for (int i = 1; i <= 8; i++) push(4'(i));
        check("fill_count",    32'(count),    32'd8);
        check("fill_full",     32'(full),     32'd1);
        check("fill_wr_ready", 32'(wr_ready), 32'd0);
        check("fill_ovf_pre",  32'(ovf),      32'd0);
        wr_valid = 1'b1;
        wr_data  = 4'd9;
        tick();
        wr_valid = 1'b0;
        check("ovf_count",   32'(count),   32'd8);
        check("ovf_flag",    32'(ovf),     32'd1);
        check("ovf_rd_data", 32'(rd_data), 32'd1);
        drain(8);
        check("ovf_drained_empty", 32'(empty), 32'd1);
        check("ovf_sticky",        32'(ovf),   32'd1);

        // Asynchronous reset mid-operation discards contents.
        for (int i = 0; i < 5; i++) push(4'(i + 2));
        check("prereset_count", 32'(count), 32'd5);
        #2;
        clr_n = 1'b0;
        exp_q.delete();
        #1;
        check_idle_reset("async_reset");
        @(negedge clk);
        clr_n = 1'b1;
        tick();
        check("post_reset_count", 32'(count), 32'd0);
        push(4'hC);
        check("post_reset_rd_data", 32'(rd_data), 32'hC);
        drain(1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asr8_fifo.md
ASR8_FIFO -- requirements
Module: asr8_fifo

Interface
REQ-001 Parameter: N, default 4, data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: clr_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: wr_valid  input  1  write request; word on wr_data is offered.
REQ-005 Port: wr_data  input  N  write word.
REQ-006 Port: wr_ready  output  1  block can accept a word this cycle.
REQ-007 Port: rd_valid  output  1  rd_data holds the oldest stored word.
REQ-008 Port: rd_data  output  N  oldest stored word, first-word fall-through.
REQ-009 Port: rd_ready  input  1  consumer takes rd_data this cycle.
REQ-010 Port: count  output  4  number of stored words, 0..8.
REQ-011 Port: full  output  1  count == 8.
REQ-012 Port: empty  output  1  count == 0.
REQ-013 Port: ovf  output  1  sticky overflow flag.

Function
REQ-014 Storage SHALL be an 8-stage shift register sr[0..7] of N bits each; a push loads sr[0] <= wr_data and sr[i] <= sr[i-1] for i = 1..7.
REQ-015 The read tap SHALL be an internal 3-bit address equal to count-1; rd_data = sr[count-1] when count > 0, else all zeros.
REQ-016 Push SHALL occur on a rising edge when wr_valid && wr_ready; pop SHALL occur when rd_valid && rd_ready.
REQ-017 wr_ready SHALL equal ~full (no combinational path from rd_ready); rd_valid SHALL equal ~empty.
REQ-018 Push only: count increments by 1; pop only: count decrements by 1, storage not shifted.
REQ-019 Simultaneous push and pop (count 1..7): storage shifts, count unchanged, next rd_data = the word following the popped one in write order.
REQ-020 Latency: a word pushed into an empty block SHALL appear on rd_data with rd_valid=1 on the cycle after the push edge.
REQ-021 Words SHALL be read in exactly the order written (FIFO order), with no loss or duplication.
REQ-022 wr_valid=1 while full: word dropped, storage and count unchanged, ovf set to 1 on that edge.
REQ-023 ovf SHALL remain 1 until reset; rd_ready while empty SHALL have no effect and not set ovf.
REQ-024 full, empty, count and rd_valid SHALL be derived from the registered count only.

Reset
REQ-025 clr_n=0 SHALL immediately (asynchronously) force count=0, sr[0..7]=0, ovf=0, hence empty=1, full=0, rd_valid=0, wr_ready=1, rd_data=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; the first push after clr_n rises is the first word read.
REQ-027 clr_n deassertion SHALL take effect at the next rising clk edge; no push or pop occurs on an edge where clr_n=0.

Verification
REQ-028 Reset then push 3,2,4,5 (one per cycle, rd_ready=0) -> count=4, rd_data=3; then rd_ready=1 for 4 cycles -> rd_data 3,2,4,5 in turn, then empty=1, rd_data=0.
REQ-029 Push 8 words 1..8 -> full=1, wr_ready=0; push 9 with wr_valid=1 -> count stays 8, ovf=1; drain -> reads 1..8, ovf still 1.
REQ-030 With count=3 holding 7,6,5 (7 oldest), push 9 and pop together for 1 cycle -> count=3, rd_data=6; drain -> 6,5,9.
REQ-031 Push 0xA into empty block -> same cycle rd_valid=0; next cycle rd_valid=1, rd_data=0xA.
REQ-032 With count=5, assert clr_n=0 between clock edges -> count=0, empty=1, rd_data=0 immediately; after release push 0xC -> next read 0xC.
REQ-033 Pop with empty=1 and rd_ready=1 for 3 cycles -> count stays 0, ovf stays 0, rd_valid stays 0.
